// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Writeback stage that owns the register file's single write port. Results
// from the ALU and the load unit arrive on valid/ready handshakes, are buffered
// in a small in-order FIFO and retired one per cycle. Operand fetch can ask
// whether any buffered entry still targets a given register (RAW hazard check).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_addr/alu_data   ALU result handshake
//   mem_valid/mem_ready/mem_addr/mem_data   load result handshake
//   write_enable/write_addr/write_data      register file write port
//   count                            occupied FIFO entries
//   query_addr/query_pending         pending-write lookup for operand fetch
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [ADDR_WIDTH-1:0]        alu_addr,
   input  logic [DATA_WIDTH-1:0]        alu_data,
   input  logic                         mem_valid,
   output logic                         mem_ready,
   input  logic [ADDR_WIDTH-1:0]        mem_addr,
   input  logic [DATA_WIDTH-1:0]        mem_data,
   output logic                         write_enable,
   output logic [ADDR_WIDTH-1:0]        write_addr,
   output logic [DATA_WIDTH-1:0]        write_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   input  logic [ADDR_WIDTH-1:0]        query_addr,
   output logic                         query_pending
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // Which producer won the most recent contended cycle.
   typedef enum logic {
      RR_ALU = 1'b0,
      RR_MEM = 1'b1
   } rr_e;

   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count_q;
   rr_e                   rr_last;

   logic          pop;
   logic [CW-1:0] free;
   logic          free_many;
   logic          contention;
   logic          alu_push;
   logic          mem_push;
   logic [PW-1:0] alu_slot;
   logic [PW-1:0] offset;

   // The register file always accepts, so the head leaves on every edge
   // where anything is buffered.
   assign pop = (count_q != '0);

   // A slot freed by this cycle's retirement is reusable at the same edge,
   // which is why free never drops below one.
   assign free      = CW'(DEPTH) - count_q + CW'(pop);
   assign free_many = (free > CW'(1));

   // With a single free slot and both producers valid, exactly one ready is
   // raised; each ready looks only at the other producer's valid.
   always_comb begin
      alu_ready = 1'b1;
      mem_ready = 1'b1;
      if (!free_many) begin
         mem_ready = !alu_valid || (rr_last == RR_ALU);
         alu_ready = !mem_valid || (rr_last == RR_MEM);
      end
   end

   assign contention = !free_many && alu_valid && mem_valid;
   assign alu_push   = alu_valid && alu_ready;
   assign mem_push   = mem_valid && mem_ready;

   // On a dual enqueue the load result takes the first slot so the ALU value
   // retires last and wins a same-address collision.
   assign alu_slot = wr_ptr + PW'(mem_push);

   // NOTE: the storage array has no reset; validity is tracked solely by
   // count and the pointers, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (mem_push) begin
         addr_q[wr_ptr] <= mem_addr;
         data_q[wr_ptr] <= mem_data;
      end
      if (alu_push) begin
         addr_q[alu_slot] <= alu_addr;
         data_q[alu_slot] <= alu_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         rr_last <= RR_ALU;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the wrap.
         rd_ptr  <= rd_ptr + PW'(pop);
         wr_ptr  <= wr_ptr + PW'(alu_push) + PW'(mem_push);
         count_q <= count_q + CW'(alu_push) + CW'(mem_push) - CW'(pop);
         if (contention) begin
            rr_last <= (rr_last == RR_ALU) ? RR_MEM : RR_ALU;
         end
      end
   end

   assign write_enable = pop;
   assign write_addr   = addr_q[rd_ptr];
   assign write_data   = data_q[rd_ptr];
   assign count        = count_q;

   // An entry is occupied when its distance from the head is below count;
   // the head itself counts even though it retires this cycle.
   // NOTE: every variable driven here gets a default first so no latch is
   // inferred.
   always_comb begin
      query_pending = 1'b0;
      offset        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = PW'(i) - rd_ptr;
         if ((CW'(offset) < count_q) && (addr_q[i] == query_addr)) begin
            query_pending = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed self-checking bench for regfile_wb_arbiter. Inputs change on the
// falling edge; outputs are compared 1 time unit later, well away from the
// rising edge that updates the design.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   localparam int DW    = 64;
   localparam int AW    = 6;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alu_valid, alu_ready, mem_valid, mem_ready;
   logic [AW-1:0] alu_addr, mem_addr, write_addr, query_addr;
   logic [DW-1:0] alu_data, mem_data, write_data;
   logic          write_enable, query_pending;
   logic [CW-1:0] count;

   int vectors     = 0;
   int miscompares = 0;

   regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_addr     (alu_addr),
      .alu_data     (alu_data),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .count        (count),
      .query_addr   (query_addr),
      .query_pending(query_pending)
   );

   always #5 clk = ~clk;

   task automatic idle();
      alu_valid = 1'b0;
      mem_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0; query_addr = '0;
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (count !== 0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
      vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", write_enable); end
      vectors++; if (query_pending !== 1'b0) begin miscompares++; $display("FAIL reset_qp: got %b want 0", query_pending); end
      vectors++; if ({alu_ready, mem_ready} !== 2'b11) begin miscompares++; $display("FAIL reset_ready: got %b want 11", {alu_ready, mem_ready}); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      alu_valid = 1'b1; alu_addr = 6'd0; alu_data = 64'hA5A5_A5A5_A5A5_A5A5;
      #1;
      vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", alu_ready); end
      @(negedge clk);
      idle();
      #1;
      vectors++; if (write_enable !== 1'b1) begin miscompares++; $display("FAIL single_we: got %b want 1", write_enable); end
      vectors++; if (write_addr !== 6'd0) begin miscompares++; $display("FAIL single_addr: got %0d want 0", write_addr); end
      vectors++; if (write_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin miscompares++; $display("FAIL single_data: got %h want a5a5a5a5a5a5a5a5", write_data); end
      vectors++; if (count !== 1) begin miscompares++; $display("FAIL single_count1: got %0d want 1", count); end
      @(negedge clk);
      #1;
      vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL single_we_off: got %b want 0", write_enable); end
      vectors++; if (count !== 0) begin miscompares++; $display("FAIL single_count0: got %0d want 0", count); end
   endtask

   task automatic test_dual();
      @(negedge clk);
      mem_valid = 1'b1; mem_addr = 6'd1;  mem_data = 64'h5A5A_5A5A_5A5A_5A5A;
      alu_valid = 1'b1; alu_addr = 6'd63; alu_data = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      vectors++; if ({alu_ready, mem_ready} !== 2'b11) begin miscompares++; $display("FAIL dual_ready: got %b want 11", {alu_ready, mem_ready}); end
      @(negedge clk);
      idle();
      #1;
      vectors++; if (count !== 2) begin miscompares++; $display("FAIL dual_count: got %0d want 2", count); end
      vectors++; if (write_enable !== 1'b1 || write_addr !== 6'd1 || write_data !== 64'h5A5A_5A5A_5A5A_5A5A) begin
         miscompares++; $display("FAIL dual_first: got we=%b addr=%0d data=%h want we=1 addr=1 data=5a5a5a5a5a5a5a5a", write_enable, write_addr, write_data); end
      @(negedge clk);
      #1;
      vectors++; if (write_enable !== 1'b1 || write_addr !== 6'd63 || write_data !== 64'hDEAD_BEEF_DEAD_BEEF) begin
         miscompares++; $display("FAIL dual_second: got we=%b addr=%0d data=%h want we=1 addr=63 data=deadbeefdeadbeef", write_enable, write_addr, write_data); end
      @(negedge clk);
      #1;
      vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL dual_we_off: got %b want 0", write_enable); end
   endtask

   task automatic test_same_addr();
      @(negedge clk);
      query_addr = 6'd5;
      mem_valid = 1'b1; mem_addr = 6'd5; mem_data = 64'h11;
      alu_valid = 1'b1; alu_addr = 6'd5; alu_data = 64'h22;
      #1;
      vectors++; if (query_pending !== 1'b0) begin miscompares++; $display("FAIL same_qp_pre: got %b want 0", query_pending); end
      @(negedge clk);
      idle();
      #1;
      vectors++; if (query_pending !== 1'b1) begin miscompares++; $display("FAIL same_qp1: got %b want 1", query_pending); end
      vectors++; if (write_enable !== 1'b1 || write_addr !== 6'd5 || write_data !== 64'h11) begin
         miscompares++; $display("FAIL same_first: got we=%b addr=%0d data=%h want we=1 addr=5 data=11", write_enable, write_addr, write_data); end
      @(negedge clk);
      #1;
      vectors++; if (query_pending !== 1'b1) begin miscompares++; $display("FAIL same_qp2: got %b want 1", query_pending); end
      vectors++; if (write_enable !== 1'b1 || write_addr !== 6'd5 || write_data !== 64'h22) begin
         miscompares++; $display("FAIL same_second: got we=%b addr=%0d data=%h want we=1 addr=5 data=22", write_enable, write_addr, write_data); end
      @(negedge clk);
      #1;
      vectors++; if (query_pending !== 1'b0) begin miscompares++; $display("FAIL same_qp_done: got %b want 0", query_pending); end
      vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL same_we_off: got %b want 0", write_enable); end
   endtask

   // Both producers held valid for 12 cycles. Grants are hand-derived:
   // cycles 0-2 accept both (count 0,2,3), then the FIFO sits at 4 and the
   // single slot alternates mem, alu, mem, ... starting with mem.
   task automatic test_back_to_back();
      entry_t q[$];
      entry_t e;
      int ai = 0;
      int mi = 0;
      int exp_count;
      bit exp_mem, exp_alu;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         alu_valid = 1'b1; alu_addr = AW'(32 + ai); alu_data = 64'hA1A1_0000_0000_0000 | DW'(ai);
         mem_valid = 1'b1; mem_addr = AW'(mi);      mem_data = 64'h3C3C_0000_0000_0000 | DW'(mi);
         exp_mem   = (k < 3) || (((k - 3) % 2) == 0);
         exp_alu   = (k < 3) || (((k - 3) % 2) == 1);
         exp_count = (k == 0) ? 0 : (k == 1) ? 2 : (k == 2) ? 3 : 4;
         #1;
         vectors++; if (mem_ready !== exp_mem || alu_ready !== exp_alu) begin
            miscompares++; $display("FAIL b2b_grant[%0d]: got mem=%b alu=%b want mem=%b alu=%b", k, mem_ready, alu_ready, exp_mem, exp_alu); end
         vectors++; if (count !== exp_count) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d want %0d", k, count, exp_count); end
         if (k > 0) begin
            e = q.pop_front();
            vectors++; if (write_enable !== 1'b1 || write_addr !== e.addr || write_data !== e.data) begin
               miscompares++; $display("FAIL b2b_retire[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", k, write_enable, write_addr, write_data, e.addr, e.data); end
         end
         if (exp_mem) begin e.addr = AW'(mi); e.data = 64'h3C3C_0000_0000_0000 | DW'(mi); q.push_back(e); mi++; end
         if (exp_alu) begin e.addr = AW'(32 + ai); e.data = 64'hA1A1_0000_0000_0000 | DW'(ai); q.push_back(e); ai++; end
      end
      @(negedge clk);
      idle();
      for (int j = 0; j < 8 && q.size() != 0; j++) begin
         if (j != 0) @(negedge clk);
         #1;
         e = q.pop_front();
         vectors++; if (write_enable !== 1'b1 || write_addr !== e.addr || write_data !== e.data) begin
            miscompares++; $display("FAIL b2b_drain[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", j, write_enable, write_addr, write_data, e.addr, e.data); end
         vectors++; if (count !== 4 - j) begin miscompares++; $display("FAIL b2b_drain_count[%0d]: got %0d want %0d", j, count, 4 - j); end
      end
      @(negedge clk);
      #1;
      vectors++; if (write_enable !== 1'b0 || count !== 0) begin
         miscompares++; $display("FAIL b2b_empty: got we=%b count=%0d want we=0 count=0", write_enable, count); end
   endtask

   // Last contention of the previous test went to mem, so only a reset can
   // make mem win the next contention.
   task automatic test_reset_midstream();
      @(negedge clk);
      mem_valid = 1'b1; mem_addr = 6'd10; mem_data = 64'h10;
      alu_valid = 1'b1; alu_addr = 6'd11; alu_data = 64'h11;
      @(negedge clk);
      mem_addr = 6'd12; mem_data = 64'h12;
      alu_addr = 6'd13; alu_data = 64'h13;
      @(negedge clk);
      idle();
      query_addr = 6'd12;
      #1;
      vectors++; if (count !== 3) begin miscompares++; $display("FAIL mid_count_pre: got %0d want 3", count); end
      vectors++; if (query_pending !== 1'b1) begin miscompares++; $display("FAIL mid_qp_pre: got %b want 1", query_pending); end
      #1;
      rst_n = 1'b0;
      #1;
      vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL mid_we_async: got %b want 0", write_enable); end
      vectors++; if (count !== 0) begin miscompares++; $display("FAIL mid_count_async: got %0d want 0", count); end
      vectors++; if (query_pending !== 1'b0) begin miscompares++; $display("FAIL mid_qp_async: got %b want 0", query_pending); end
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         vectors++; if (write_enable !== 1'b0 || count !== 0) begin
            miscompares++; $display("FAIL mid_stale[%0d]: got we=%b count=%0d want we=0 count=0", k, write_enable, count); end
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         mem_valid = 1'b1; mem_addr = AW'(20 + k); mem_data = DW'(k);
         alu_valid = 1'b1; alu_addr = AW'(40 + k); alu_data = DW'(k);
      end
      #1;
      vectors++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
         miscompares++; $display("FAIL mid_first_grant: got mem=%b alu=%b want mem=1 alu=0", mem_ready, alu_ready); end
      @(negedge clk);
      idle();
      repeat (5) @(negedge clk);
      #1;
      vectors++; if (count !== 0) begin miscompares++; $display("FAIL mid_drained: got %0d want 0", count); end
   endtask

   task automatic test_query_same_cycle();
      @(negedge clk);
      query_addr = 6'd63;
      alu_valid = 1'b1; alu_addr = 6'd63; alu_data = 64'h0123_4567_89AB_CDEF;
      #1;
      vectors++; if (query_pending !== 1'b0) begin miscompares++; $display("FAIL query_same: got %b want 0", query_pending); end
      @(negedge clk);
      idle();
      #1;
      vectors++; if (query_pending !== 1'b1) begin miscompares++; $display("FAIL query_next: got %b want 1", query_pending); end
      vectors++; if (write_data !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL query_data: got %h want 0123456789abcdef", write_data); end
      @(negedge clk);
      #1;
      vectors++; if (query_pending !== 1'b0) begin miscompares++; $display("FAIL query_cleared: got %b want 0", query_pending); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_dual();
      test_same_addr();
      test_back_to_back();
      test_reset_midstream();
      test_query_same_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within 100000 time units");
      $fatal(1);
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback stage directly upstream of the 64x64 register file; owns the regfile's single write port (write_enable/write_addr/write_data).
- Merges results from two producers, the ALU and the load unit, each on a valid/ready handshake.
- Buffers results in a small in-order FIFO and retires one result per cycle.
- Exposes a pending-write query so operand fetch can detect RAW hazards on not-yet-written registers.

Parameters:
- DATA_WIDTH, 64, result and register width
- ADDR_WIDTH, 6, register address width (64 registers; register 0 is an ordinary register)
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- alu_addr  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load result valid
- mem_ready  out  1  load result accepted this cycle when high with mem_valid
- mem_addr  in  ADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load result
- write_enable  out  1  regfile write strobe
- write_addr  out  ADDR_WIDTH  regfile write address
- write_data  out  DATA_WIDTH  regfile write data
- count  out  $clog2(DEPTH+1)  occupied FIFO entries
- query_addr  in  ADDR_WIDTH  register being checked by operand fetch
- query_pending  out  1  high when a buffered entry targets query_addr

Behaviour:
- Reset (rst_n low, asynchronous): count=0, read and write pointers=0, rr_last=ALU. write_enable=0 immediately, without waiting for a clock edge. query_pending=0. Buffered entries are discarded, including when reset asserts mid-stream.
- Retire:
  - write_enable = (count != 0); write_addr/write_data = FIFO head, combinational from storage.
  - The regfile always accepts, so the head pops on every edge where count != 0.
- Transfer: a producer's handshake completes on an edge where valid & ready are both high. That entry is written into the FIFO at that edge.
- Latency: handshake at edge N, empty FIFO → write_enable high during cycle N+1 → regfile writes at edge N+1.
- Free slots: free = DEPTH − count + (count != 0), so free ≥ 1 always.
- Ready generation (combinational; may depend on the other producer's valid, never on its own):
  - free ≥ 2: alu_ready=1, mem_ready=1.
  - free == 1: mem_ready = !alu_valid | (rr_last==ALU); alu_ready = !mem_valid | (rr_last==MEM).
- Round-robin: rr_last updates to the winner only on contention edges (free==1 and both valid). Otherwise it holds. After reset, mem wins the first contention.
- Dual enqueue: the mem entry goes in first, then the alu entry. If both target the same address, the alu value is retired last and persists.
- count_next = count + pushes − pop. Pointers wrap modulo DEPTH. count never exceeds DEPTH.
- query_pending:
  - Combinational OR over all occupied entries (including the head being retired this cycle) of addr == query_addr.
  - It does not consider this cycle's producer inputs.
- Data fidelity: data and addresses pass through unmodified, with no width conversion.

Test Plan:
- Reset, then alu_valid=1, addr=0, data=A5A5A5A5A5A5A5A5 for 1 cycle → next cycle write_enable=1, write_addr=0, write_data=A5A5A5A5A5A5A5A5, then write_enable=0; count 0→1→0.
- Both valid in 1 cycle (mem addr=1, data=5A5A5A5A5A5A5A5A; alu addr=63, data=DEADBEEFDEADBEEF), empty FIFO → both ready. Retires addr 1 then addr 63 on consecutive cycles.
- Both valid with same addr=5 (mem=0x11, alu=0x22) → writes 0x11 then 0x22; query_addr=5 → query_pending=1 for 2 cycles, then 0.
- Hold both valid continuously for 12 cycles → count climbs to DEPTH=4, then only one ready per cycle. Grants alternate mem, alu, mem, …; no entry lost or duplicated; retire order matches accept order.
- Fill 3 entries, assert rst_n=0 between edges → write_enable=0, count=0 immediately. After release, no stale writes; next contention grants mem first.
- query_addr=63 with no matching entry and alu_valid=1, alu_addr=63 in the same cycle → query_pending=0 that cycle, 1 the next cycle.
